// File: rtl/sample_bank_loader_pkg.sv
// Shared constants and FSM state type for the sample bank loader.
package sample_bank_loader_pkg;
    localparam int NUM_WORDS     = 8;
    localparam int FILL_CNT_W    = 4;
    localparam int IDX_W         = 3;
    localparam int DEF_DATAWIDTH = 16;
    localparam int DEF_SAWIDTH   = 8;

    typedef enum logic {
        ST_FILL    = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;
endpackage

// File: rtl/sample_bank_loader_bank.sv
// One frame of storage: 8 sample words plus the shift amount, written one word
// at a time and read in parallel.
module sample_bank
    import sample_bank_loader_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int SAWIDTH   = DEF_SAWIDTH
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_we,
    input  logic [IDX_W-1:0]                     i_widx,
    input  logic [DATAWIDTH-1:0]                 i_wdata,
    input  logic                                 i_sa_we,
    input  logic [SAWIDTH-1:0]                   i_wsa,
    output logic [NUM_WORDS-1:0][DATAWIDTH-1:0]  o_words,
    output logic [SAWIDTH-1:0]                   o_sa
);
    logic [NUM_WORDS-1:0][DATAWIDTH-1:0] r_words;
    logic [SAWIDTH-1:0]                  r_sa;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_words <= '0;
            r_sa    <= '0;
        end else begin
            if (i_we)    r_words[i_widx] <= i_wdata;
            if (i_sa_we) r_sa            <= i_wsa;
        end
    end

    assign o_words = r_words;
    assign o_sa    = r_sa;
endmodule

// File: rtl/sample_bank_loader.sv
// Packs a serial sample stream into 8-word frames for the averager.
// Define SAMPLE_BANK_DBL_BUF_EN for a fill/present bank pair (back-to-back frames).
module sample_bank_loader
    import sample_bank_loader_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int SAWIDTH   = DEF_SAWIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATAWIDTH-1:0]  in_data,
    input  logic [SAWIDTH-1:0]    in_sa,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATAWIDTH-1:0]  a,
    output logic [DATAWIDTH-1:0]  b,
    output logic [DATAWIDTH-1:0]  c,
    output logic [DATAWIDTH-1:0]  d,
    output logic [DATAWIDTH-1:0]  e,
    output logic [DATAWIDTH-1:0]  f,
    output logic [DATAWIDTH-1:0]  g,
    output logic [DATAWIDTH-1:0]  h,
    output logic [SAWIDTH-1:0]    sa,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FILL_CNT_W-1:0] fill_cnt
);
`ifdef SAMPLE_BANK_DBL_BUF_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

    state_e                 r_state, w_state_nxt;
    logic [FILL_CNT_W-1:0]  r_fill_cnt, w_fill_cnt_nxt;
    logic                   w_in_ready, w_out_valid, w_in_xfer, w_out_xfer, w_last_word;
    logic [NUM_BANKS-1:0]   w_bank_we;
    logic [NUM_WORDS-1:0][DATAWIDTH-1:0] w_bank_words [NUM_BANKS];
    logic [SAWIDTH-1:0]                  w_bank_sa    [NUM_BANKS];
    logic [NUM_WORDS-1:0][DATAWIDTH-1:0] w_words;
    logic [SAWIDTH-1:0]                  w_sa;

    assign w_out_valid = (r_state == ST_PRESENT);
    assign w_in_xfer   = in_valid && w_in_ready;
    assign w_out_xfer  = w_out_valid && out_ready;
    assign w_last_word = w_in_xfer && (r_fill_cnt == FILL_CNT_W'(NUM_WORDS - 1));

`ifdef SAMPLE_BANK_DBL_BUF_EN
    // r_state tracks whether the present bank holds an untaken frame.
    logic r_fsel;
    logic w_full, w_swap;

    assign w_full     = (r_fill_cnt == FILL_CNT_W'(NUM_WORDS));
    assign w_in_ready = !(w_full && r_state == ST_PRESENT);
    assign w_swap     = (w_last_word || w_full) && (r_state == ST_FILL || w_out_xfer);
    assign w_bank_we  = {w_in_xfer && r_fsel, w_in_xfer && !r_fsel};
    assign w_words    = r_fsel ? w_bank_words[0] : w_bank_words[1];
    assign w_sa       = r_fsel ? w_bank_sa[0]    : w_bank_sa[1];

    always_comb begin
        w_state_nxt    = r_state;
        w_fill_cnt_nxt = r_fill_cnt;
        if (w_swap) begin
            w_state_nxt    = ST_PRESENT;
            w_fill_cnt_nxt = '0;
        end else begin
            if (w_out_xfer) w_state_nxt    = ST_FILL;
            if (w_in_xfer)  w_fill_cnt_nxt = r_fill_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         r_fsel <= 1'b0;
        else if (w_swap) r_fsel <= ~r_fsel;
    end
`else
    assign w_in_ready = (r_state == ST_FILL);
    assign w_bank_we  = w_in_xfer;
    assign w_words    = w_bank_words[0];
    assign w_sa       = w_bank_sa[0];

    always_comb begin
        w_state_nxt    = r_state;
        w_fill_cnt_nxt = r_fill_cnt;
        case (r_state)
            ST_FILL: begin
                if (w_in_xfer)   w_fill_cnt_nxt = r_fill_cnt + 1'b1;
                if (w_last_word) w_state_nxt    = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (w_out_xfer) begin
                    w_state_nxt    = ST_FILL;
                    w_fill_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FILL;
            r_fill_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_cnt_nxt;
        end
    end

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        sample_bank #(
            .DATAWIDTH (DATAWIDTH),
            .SAWIDTH   (SAWIDTH)
        ) u_bank (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_we    (w_bank_we[gb]),
            .i_widx  (r_fill_cnt[IDX_W-1:0]),
            .i_wdata (in_data),
            .i_sa_we (w_bank_we[gb] && (r_fill_cnt == '0)),
            .i_wsa   (in_sa),
            .o_words (w_bank_words[gb]),
            .o_sa    (w_bank_sa[gb])
        );
    end

    assign {h, g, f, e, d, c, b, a} = w_words;
    assign sa        = w_sa;
    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign fill_cnt  = r_fill_cnt;
endmodule
